// File: rtl/mdu_iter.sv
// HI/LO multiply/divide unit for the 5-stage MIPS core: a MUL_LAT-stage multiplier pipe and a radix-2 restoring divider.
// Define MDU_MADD_EN to enable MADD/MSUB accumulation; otherwise ops 110/111 complete as one-cycle no-ops.
module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  typedef enum logic [2:0] {
    OP_MULT = 3'b000, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MADD, OP_MSUB
  } op_t;

  state_t             state;
  op_t                opc;
  logic               accept;
  logic               is_mul;
  logic               mul_signed;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_result;
  logic [2*WIDTH-1:0] prod_pipe [MUL_LAT];
  logic [MUL_LAT-1:0] vld_pipe;
`ifdef MDU_MADD_EN
  logic [MUL_LAT-1:0] acc_pipe;
  logic [MUL_LAT-1:0] sub_pipe;
`endif

  // Divider state
  logic [CW-1:0]    cnt;
  logic             div_setup;
  logic             div_signed;
  logic             q_neg;
  logic             r_neg;
  logic             dbz;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] b_raw;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] rem_nx;
  logic             ge;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] lo_fix;
  logic [WIDTH-1:0] hi_fix;

  assign opc    = op_t'(op);
  assign accept = start && !flush && (state == IDLE);

`ifdef MDU_MADD_EN
  assign is_mul = (opc == OP_MULT) || (opc == OP_MULTU) || (opc == OP_MADD) || (opc == OP_MSUB);
`else
  assign is_mul = (opc == OP_MULT) || (opc == OP_MULTU);
`endif

  // Sign- or zero-extend to 2*WIDTH so one unsigned multiply gives the correct low half either way.
  assign mul_signed = (opc != OP_MULTU);
  assign ext_a      = {{WIDTH{mul_signed & a[WIDTH-1]}}, a};
  assign ext_b      = {{WIDTH{mul_signed & b[WIDTH-1]}}, b};
  assign prod       = ext_a * ext_b;

  // NOTE: datapath pipe registers carry no reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    prod_pipe[0] <= prod;
    for (int i = 1; i < MUL_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
`ifdef MDU_MADD_EN
    acc_pipe[0] <= (opc == OP_MADD) || (opc == OP_MSUB);
    sub_pipe[0] <= (opc == OP_MSUB);
    for (int i = 1; i < MUL_LAT; i++) begin
      acc_pipe[i] <= acc_pipe[i-1];
      sub_pipe[i] <= sub_pipe[i-1];
    end
`endif
  end

  // NOTE: assigning a default first keeps this always_comb free of latches.
  always_comb begin
    mul_result = prod_pipe[MUL_LAT-1];
`ifdef MDU_MADD_EN
    if (acc_pipe[MUL_LAT-1])
      mul_result = sub_pipe[MUL_LAT-1] ? ({hi, lo} - prod_pipe[MUL_LAT-1])
                                       : ({hi, lo} + prod_pipe[MUL_LAT-1]);
`endif
  end

  // rem < dvsr always holds, so a set rem MSB means the shifted value exceeds any divisor.
  assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign ge     = rem[WIDTH-1] | (rem_sh >= dvsr);
  assign rem_nx = ge ? (rem_sh - dvsr) : rem_sh;

  assign a_abs  = (div_signed && a_raw[WIDTH-1]) ? -a_raw : a_raw;
  assign b_abs  = (div_signed && b_raw[WIDTH-1]) ? -b_raw : b_raw;
  assign lo_fix = dbz ? '1 : (q_neg ? -quo : quo);
  assign hi_fix = dbz ? a_raw : (r_neg ? -rem : rem);

  // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      vld_pipe   <= '0;
      cnt        <= '0;
      div_setup  <= 1'b0;
      div_signed <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      dbz        <= 1'b0;
      a_raw      <= '0;
      b_raw      <= '0;
      dvsr       <= '0;
      quo        <= '0;
      rem        <= '0;
    end else begin
      done <= 1'b0;

      vld_pipe[0] <= accept && is_mul;
      for (int i = 1; i < MUL_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];

      if (flush && busy) begin
        // Cancel: nothing reaches HI/LO and no done pulse is produced.
        state     <= IDLE;
        busy      <= 1'b0;
        div_setup <= 1'b0;
        cnt       <= '0;
        vld_pipe  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              unique case (opc)
                OP_MULT, OP_MULTU: begin
                  state <= MUL;
                  busy  <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                  state      <= DIV;
                  busy       <= 1'b1;
                  div_setup  <= 1'b1;
                  div_signed <= (opc == OP_DIV);
                  a_raw      <= a;
                  b_raw      <= b;
                  cnt        <= CW'(WIDTH - 1);
                end
                OP_MTHI: begin
                  hi   <= a;
                  done <= 1'b1;
                end
                OP_MTLO: begin
                  lo   <= a;
                  done <= 1'b1;
                end
                default: begin
`ifdef MDU_MADD_EN
                  state <= MUL;
                  busy  <= 1'b1;
`else
                  done  <= 1'b1;
`endif
                end
              endcase
            end
          end
          MUL: begin
            if (vld_pipe[MUL_LAT-1]) begin
              {hi, lo} <= mul_result;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
          DIV: begin
            if (div_setup) begin
              div_setup <= 1'b0;
              quo       <= a_abs;
              dvsr      <= b_abs;
              rem       <= '0;
              q_neg     <= div_signed && (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
              r_neg     <= div_signed && a_raw[WIDTH-1];
              dbz       <= (b_raw == '0);
            end else begin
              rem <= rem_nx;
              quo <= {quo[WIDTH-2:0], ge};
              if (cnt == '0) state <= FIX;
              else           cnt   <= cnt - 1'b1;
            end
          end
          FIX: begin
            lo    <= lo_fix;
            hi    <= hi_fix;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32, MUL_LAT=3): vector table plus flush/reset corner sequences.
module tb_mdu_iter;
  localparam int W = 32;
  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                         MTHI = 3'd4, MTLO = 3'd5, MADD = 3'd6, MSUB = 3'd7;
  localparam int MLAT = 3;
  localparam int DLAT = W + 2;
  localparam int NV   = 17;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;
  vec_t tbl [NV];

  mdu_iter #(.WIDTH(W), .MUL_LAT(MLAT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input int l, input logic [W-1:0] eh, input logic [W-1:0] el);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.lat = l; v.hi = eh; v.lo = el;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, count edges from the accepting edge until done, then check results.
  task automatic run_op(input string tag, input vec_t v);
    int   n;
    logic busy_ok;
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(v.lat));
    if (v.lat > 0) check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(v.hi));
    check({tag, "_lo"}, 64'(lo), 64'(v.lo));
    tick();
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic         seen_done;
    logic [W-1:0] keep_hi;
    logic [W-1:0] keep_lo;

    tbl[0]  = mk(MULT,  32'hFFFF_FFFE, 32'h0000_0003, MLAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    tbl[1]  = mk(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MLAT, 32'hFFFF_FFFE, 32'h0000_0001);
    tbl[2]  = mk(DIV,   32'hFFFF_FFF9, 32'h0000_0002, DLAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    tbl[3]  = mk(DIVU,  32'h0000_0007, 32'h0000_0000, DLAT, 32'h0000_0007, 32'hFFFF_FFFF);
    tbl[4]  = mk(DIV,   32'h8000_0000, 32'hFFFF_FFFF, DLAT, 32'h0000_0000, 32'h8000_0000);
    tbl[5]  = mk(MTHI,  32'h0000_1234, 32'h0,         0,    32'h0000_1234, 32'h8000_0000);
    tbl[6]  = mk(MTLO,  32'h0000_5678, 32'h0,         0,    32'h0000_1234, 32'h0000_5678);
    tbl[7]  = mk(DIV,   32'h0000_0007, 32'hFFFF_FFFE, DLAT, 32'h0000_0001, 32'hFFFF_FFFD);
    tbl[8]  = mk(DIVU,  32'hFFFF_FFFF, 32'h0000_000A, DLAT, 32'h0000_0005, 32'h1999_9999);
    tbl[9]  = mk(DIV,   32'hFFFF_FFF9, 32'h0000_0000, DLAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    tbl[10] = mk(MULT,  32'h8000_0000, 32'h8000_0000, MLAT, 32'h4000_0000, 32'h0000_0000);
    tbl[11] = mk(MULT,  32'hFFFF_FFFF, 32'h0000_0005, MLAT, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    tbl[12] = mk(DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, DLAT, 32'hFFFF_FFFE, 32'h0000_0002);
    tbl[13] = mk(MTHI,  32'h0000_0000, 32'h0,         0,    32'h0000_0000, 32'h0000_0002);
    tbl[14] = mk(MTLO,  32'h0000_0005, 32'h0,         0,    32'h0000_0000, 32'h0000_0005);
`ifdef MDU_MADD_EN
    tbl[15] = mk(MADD,  32'h0000_0003, 32'h0000_0004, MLAT, 32'h0000_0000, 32'h0000_0011);
    tbl[16] = mk(MSUB,  32'h0000_000A, 32'h0000_0002, MLAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
    tbl[15] = mk(MADD,  32'h0000_0003, 32'h0000_0004, 0,    32'h0000_0000, 32'h0000_0005);
    tbl[16] = mk(MSUB,  32'h0000_000A, 32'h0000_0002, 0,    32'h0000_0000, 32'h0000_0005);
`endif

    // Reset state
    repeat (3) tick();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_op($sformatf("v%0d", i), tbl[i]);

    // Flush a DIVU mid-flight; a start issued while busy must be ignored.
    keep_hi = tbl[NV-1].hi;
    keep_lo = tbl[NV-1].lo;
    op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("fl_busy_accept", 64'(busy), 64'd1);
    repeat (3) tick();
    op = MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy_clear", 64'(busy), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check("fl_no_done", 64'(seen_done), 64'd0);
    check("fl_hi_keep", 64'(hi), 64'(keep_hi));
    check("fl_lo_keep", 64'(lo), 64'(keep_lo));
    run_op("fl_after", mk(MULTU, 32'd6, 32'd7, MLAT, 32'd0, 32'd42));

    // Flush while idle does nothing.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("idle_fl_busy", 64'(busy), 64'd0);
    check("idle_fl_done", 64'(done), 64'd0);
    check("idle_fl_lo", 64'(lo), 64'd42);

    // Start together with flush is ignored.
    op = MTLO; a = 32'h0000_BEEF; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("stfl_done", 64'(done), 64'd0);
    check("stfl_busy", 64'(busy), 64'd0);
    tick();
    check("stfl_lo", 64'(lo), 64'd42);

    // Flush in the done cycle does not undo the committed result.
    op = MULT; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !done; i++) tick();
    check("fldone_done", 64'(done), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fldone_hi", 64'(hi), 64'd0);
    check("fldone_lo", 64'(lo), 64'd6);
    check("fldone_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a divide.
    op = DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    run_op("post_rst", tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
